// File: rtl/int_ctrl.sv
// Interrupt controller: per-source mask and edge/level trigger, fixed priority
// (lowest index wins), and an IDLE/REQ/SERVICE handshake with the CPU.
module int_ctrl #(
  parameter int unsigned NSRC = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src_irq,
  input  logic [1:0]      addr,
  input  logic            we,
  input  logic [31:0]     din,
  output logic [31:0]     dout,
  output logic            int_req,
  output logic [2:0]      int_id,
  input  logic            int_ack,
  input  logic            eoi,
  output logic [NSRC-1:0] src_ack
);

  localparam int unsigned DW  = 32;
  localparam int unsigned IDW = 3;

  localparam logic [1:0] A_MASK   = 2'd0;
  localparam logic [1:0] A_MODE   = 2'd1;
  localparam logic [1:0] A_PEND   = 2'd2;
  localparam logic [1:0] A_STATUS = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [NSRC-1:0] mask_q, mode_q, pend_edge_q, prev_q;
  logic [NSRC-1:0] pend_edge_d;
  logic            primed_q;
  logic            int_req_d;
  logic [IDW-1:0]  int_id_d;
  logic [NSRC-1:0] src_ack_d;

  logic [NSRC-1:0] rise, pend, cand, id_vec, pend_clr;
  logic [IDW-1:0]  cand_id;
  logic            cand_any, id_live, ack_take;
  logic            wr_mask, wr_mode, wr_pend;
  logic [DW-1:0]   unused_din;

  assign unused_din = din;

  assign wr_mask = we && (addr == A_MASK);
  assign wr_mode = we && (addr == A_MODE);
  assign wr_pend = we && (addr == A_PEND);

  // primed_q masks the first sample after reset so a held-high line is not an edge
  assign rise     = primed_q ? (src_irq & ~prev_q) : '0;
  assign pend     = (mode_q & pend_edge_q) | (~mode_q & src_irq);
  assign cand     = pend & mask_q;
  assign cand_any = |cand;
  assign id_vec   = NSRC'(1) << int_id;
  assign id_live  = |(cand & id_vec);
  assign ack_take = (state_q == REQ) && int_ack;

  // Lowest pending-and-enabled index
  always_comb begin
    cand_id = '0;
    for (int i = int'(NSRC) - 1; i >= 0; i--) begin
      if (cand[i]) cand_id = IDW'(i);
    end
  end

  // Edge-pending bits: a fresh edge beats any clear in the same cycle
  always_comb begin
    pend_clr = '0;
    if (wr_pend)  pend_clr = pend_clr | din[NSRC-1:0];
    if (ack_take) pend_clr = pend_clr | id_vec;
    pend_edge_d = (pend_edge_q & ~pend_clr) | (rise & mode_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_q      <= '0;
      mode_q      <= '0;
      pend_edge_q <= '0;
      prev_q      <= '0;
      primed_q    <= 1'b0;
    end else begin
      if (wr_mask) mask_q <= din[NSRC-1:0];
      if (wr_mode) mode_q <= din[NSRC-1:0];
      pend_edge_q <= pend_edge_d;
      prev_q      <= src_irq;
      primed_q    <= 1'b1;
    end
  end

  // FSM state and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      int_req <= 1'b0;
      int_id  <= '0;
      src_ack <= '0;
    end else begin
      state_q <= state_d;
      int_req <= int_req_d;
      int_id  <= int_id_d;
      src_ack <= src_ack_d;
    end
  end

  // Next state; int_id is frozen outside IDLE (no preemption)
  always_comb begin
    state_d   = state_q;
    int_id_d  = int_id;
    src_ack_d = '0;
    int_req_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (cand_any) begin
          state_d  = REQ;
          int_id_d = cand_id;
        end
      end
      REQ: begin
        if (int_ack) begin
          state_d   = SERVICE;
          src_ack_d = id_vec;
        end else if (!id_live) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (eoi) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    int_req_d = (state_d == REQ);
  end

  // Register read mux
  always_comb begin
    dout = '0;
    case (addr)
      A_MASK:   dout = DW'(mask_q);
      A_MODE:   dout = DW'(mode_q);
      A_PEND:   dout = DW'(pend);
      A_STATUS: dout = {27'b0, state_q == SERVICE, state_q == REQ, int_id};
      default:  dout = '0;
    endcase
  end

endmodule
